matrix_driver: RTL

Wishbone slave that holds the 8x8 LED matrix picture and scans it onto the row/column drive pins. It sits directly downstream of the picture-loading bus master and accepts its single-beat row writes. Each row word carries eight 4-bit pixel intensities. The block multiplexes rows one at a time with 16-step PWM brightness and a blanking gap between rows.

---
 rtl/matrix_driver.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_driver.sv
// Wishbone-writable 8x8 LED matrix picture store with a row-multiplexed 16-step PWM scanner.
// Define MATRIX_DOUBLE_BUFFER_EN for a shadow bank that is swapped into the display at frame wrap.
module matrix_driver #(
  parameter int unsigned WB_DATA_WIDTH   = 32,
  parameter int unsigned REG_COUNT       = 8,
  parameter int unsigned WB_ADDR_WIDTH   = $clog2(REG_COUNT),
  parameter int unsigned WB_SEL_WIDTH    = WB_DATA_WIDTH / 8,
  parameter int unsigned PWM_STEP_CYCLES = 1,
  parameter int unsigned BLANK_CYCLES    = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_wb_cyc,
  input  logic                       i_wb_stb,
  input  logic                       i_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0]   i_wb_addr,
  input  logic [WB_SEL_WIDTH-1:0]    i_wb_sel,
  input  logic [WB_DATA_WIDTH-1:0]   i_wb_wdata,
  output logic                       o_wb_ack,
  output logic                       o_wb_stall,
  output logic [WB_DATA_WIDTH-1:0]   o_wb_rdata,
  output logic [REG_COUNT-1:0]       o_row,
  output logic [WB_DATA_WIDTH/4-1:0] o_col,
  output logic                       o_frame
);

  localparam int unsigned NCOL    = WB_DATA_WIDTH / 4;
  localparam int unsigned ROW_W   = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int unsigned BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned SUB_W   = (PWM_STEP_CYCLES > 1) ? $clog2(PWM_STEP_CYCLES) : 1;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  logic [WB_DATA_WIDTH-1:0] disp [REG_COUNT];
  logic                     accept_c;
  logic                     write_c;
  logic [WB_DATA_WIDTH-1:0] rd_word_c;
  logic [WB_DATA_WIDTH-1:0] wr_word_c;
  logic                     ack_q;

  state_t                   state, state_n;
  logic [BLANK_W-1:0]       blank_cnt, blank_n;
  logic [SUB_W-1:0]         sub_cnt, sub_n;
  logic [3:0]               step, step_n;
  logic [ROW_W-1:0]         row, row_n;
  logic [WB_DATA_WIDTH-1:0] step_word, step_word_c;
  logic                     wrap_c;
  logic [REG_COUNT-1:0]     row_c;
  logic [NCOL-1:0]          col_c;

  assign accept_c   = i_wb_cyc && i_wb_stb;
  assign write_c    = accept_c && i_wb_we;
  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = ack_q && i_wb_cyc;

  // Byte-lane merge of the write data onto the currently readable word
  always_comb begin
    wr_word_c = rd_word_c;
    for (int unsigned b = 0; b < WB_SEL_WIDTH; b++) begin
      if (i_wb_sel[b]) wr_word_c[8*b +: 8] = i_wb_wdata[8*b +: 8];
    end
  end

`ifdef MATRIX_DOUBLE_BUFFER_EN
  logic [WB_DATA_WIDTH-1:0] shadow [REG_COUNT];
  logic                     dirty;

  assign rd_word_c = shadow[i_wb_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) shadow[i] <= '0;
      dirty <= 1'b0;
    end else begin
      if (write_c) shadow[i_wb_addr] <= wr_word_c;
      // A write coinciding with the swap keeps dirty so it is picked up next frame
      if (write_c)            dirty <= 1'b1;
      else if (wrap_c)        dirty <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) disp[i] <= '0;
    end else if (wrap_c && dirty) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) disp[i] <= shadow[i];
    end
  end
`else
  assign rd_word_c = disp[i_wb_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) disp[i] <= '0;
    end else if (write_c) begin
      disp[i_wb_addr] <= wr_word_c;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q      <= 1'b0;
      o_wb_rdata <= '0;
    end else begin
      ack_q <= accept_c;
      if (accept_c && !i_wb_we) o_wb_rdata <= rd_word_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_BLANK;
      blank_cnt <= '0;
      sub_cnt   <= '0;
      step      <= '0;
      row       <= '0;
      step_word <= '0;
      o_row     <= '0;
      o_col     <= '0;
      o_frame   <= 1'b0;
    end else begin
      state     <= state_n;
      blank_cnt <= blank_n;
      sub_cnt   <= sub_n;
      step      <= step_n;
      row       <= row_n;
      step_word <= step_word_c;
      o_row     <= row_c;
      o_col     <= col_c;
      o_frame   <= wrap_c;
    end
  end

  // Scan sequencing; the row word is sampled only at step boundaries so writes never split a step
  always_comb begin
    state_n     = state;
    blank_n     = blank_cnt;
    sub_n       = sub_cnt;
    step_n      = step;
    row_n       = row;
    step_word_c = step_word;
    wrap_c      = 1'b0;
    row_c       = '0;
    col_c       = '0;
    case (state)
      ST_BLANK: begin
        if (blank_cnt == BLANK_W'(BLANK_CYCLES - 1)) begin
          blank_n = '0;
          state_n = ST_SHOW;
        end else begin
          blank_n = BLANK_W'(blank_cnt + 1'b1);
        end
      end
      ST_SHOW: begin
        if (sub_cnt == '0) step_word_c = disp[row];
        row_c = REG_COUNT'(1) << row;
        for (int unsigned c = 0; c < NCOL; c++) col_c[c] = step_word_c[4*c +: 4] > step;
        if (sub_cnt == SUB_W'(PWM_STEP_CYCLES - 1)) begin
          sub_n = '0;
          if (step == 4'hF) begin
            step_n  = '0;
            state_n = ST_BLANK;
            if (row == ROW_W'(REG_COUNT - 1)) begin
              row_n  = '0;
              wrap_c = 1'b1;
            end else begin
              row_n = ROW_W'(row + 1'b1);
            end
          end else begin
            step_n = 4'(step + 4'd1);
          end
        end else begin
          sub_n = SUB_W'(sub_cnt + 1'b1);
        end
      end
      default: state_n = ST_BLANK;
    endcase
  end

endmodule
